// File: rtl/ext_pipe.sv
// Pipelined immediate/load-data extension unit with a two-entry skid buffer and a saturating error counter.
// Optional feature macro: EXT_LOAD_EN (byte/halfword load modes, ops 4-7); without it those ops are reserved.
module ext_pipe #(
   parameter int IN_W      = 16,
   parameter int OUT_W     = 32,
   parameter int ERR_CNT_W = 8
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [2:0]                   in_op,
   input  logic [OUT_W-1:0]             in_data,
   input  logic [$clog2(OUT_W/8)-1:0]   in_addr,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [OUT_W-1:0]             out_data,
   output logic                         out_err,
   output logic [ERR_CNT_W-1:0]         err_cnt
);

   localparam int AW = $clog2(OUT_W/8);

   // Returns {err, data} for one operation; load lanes are reached by shifting the word down by addr bytes.
   function automatic logic [OUT_W:0] ext_f(input logic [2:0] op, input logic [OUT_W-1:0] data,
                                           input logic [AW-1:0] addr);
      logic [IN_W-1:0]  imm;
      logic [OUT_W-1:0] sext;
      logic [OUT_W:0]   res;
`ifdef EXT_LOAD_EN
      logic [OUT_W-1:0] lane;
      lane = data >> {addr, 3'b000};
`endif
      imm  = data[IN_W-1:0];
      sext = OUT_W'($signed(imm));
      case (op)
         3'd0: res = {1'b0, OUT_W'(imm)};
         3'd1: res = {1'b0, sext};
         3'd2: res = {1'b0, OUT_W'(imm) << (OUT_W - IN_W)};
         3'd3: res = {1'b0, sext << 2};
`ifdef EXT_LOAD_EN
         3'd4: res = {1'b0, OUT_W'(lane[7:0])};
         3'd5: res = {1'b0, OUT_W'($signed(lane[7:0]))};
         3'd6, 3'd7: begin
            if (addr[0]) begin
               res = {1'b1, {OUT_W{1'b0}}};
            end else if (op[0]) begin
               res = {1'b0, OUT_W'($signed(lane[15:0]))};
            end else begin
               res = {1'b0, OUT_W'(lane[15:0])};
            end
         end
`endif
         default: res = {1'b1, {OUT_W{1'b0}}};
      endcase
      return res;
   endfunction

   logic                 main_valid_r, skid_valid_r;
   logic [OUT_W-1:0]     main_data_r, skid_data_r;
   logic                 main_err_r, skid_err_r;
   logic [ERR_CNT_W-1:0] err_cnt_r;
   logic [OUT_W-1:0]     new_data_s;
   logic                 new_err_s;
   logic                 accept_s, pop_s;

   assign {new_err_s, new_data_s} = ext_f(in_op, in_data, in_addr);
   assign accept_s = in_valid & ~skid_valid_r;
   assign pop_s    = main_valid_r & out_ready;

   // Main/skid buffer: main feeds the outputs, skid absorbs one item while main is stalled.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         main_valid_r <= 1'b0;
         main_data_r  <= {OUT_W{1'b0}};
         main_err_r   <= 1'b0;
         skid_valid_r <= 1'b0;
         skid_data_r  <= {OUT_W{1'b0}};
         skid_err_r   <= 1'b0;
      end else if (flush) begin
         main_valid_r <= 1'b0;
         skid_valid_r <= 1'b0;
      end else if (!main_valid_r || pop_s) begin
         if (skid_valid_r) begin
            main_valid_r <= 1'b1;
            main_data_r  <= skid_data_r;
            main_err_r   <= skid_err_r;
            skid_valid_r <= 1'b0;
         end else if (accept_s) begin
            main_valid_r <= 1'b1;
            main_data_r  <= new_data_s;
            main_err_r   <= new_err_s;
         end else begin
            main_valid_r <= 1'b0;
         end
      end else if (accept_s) begin
         skid_valid_r <= 1'b1;
         skid_data_r  <= new_data_s;
         skid_err_r   <= new_err_s;
      end else begin
         skid_valid_r <= skid_valid_r;
      end
   end

   // Saturating debug count of accepted erroneous ops; a flush-cycle accept is discarded and not counted.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_cnt_r <= {ERR_CNT_W{1'b0}};
      end else if (!flush && accept_s && new_err_s && (err_cnt_r != {ERR_CNT_W{1'b1}})) begin
         err_cnt_r <= err_cnt_r + ERR_CNT_W'(1'b1);
      end else begin
         err_cnt_r <= err_cnt_r;
      end
   end

   assign in_ready  = ~skid_valid_r;
   assign out_valid = main_valid_r;
   assign out_data  = main_data_r;
   assign out_err   = main_err_r;
   assign err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_ext_pipe.sv
// Directed self-checking bench for ext_pipe: a default instance and a wide instance with a 2-bit error counter.
// Load-mode expectations follow EXT_LOAD_EN the same way the design does.
module tb_ext_pipe;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        flush = 1'b0;

   logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_err;
   logic [2:0]  in_op = 3'd0;
   logic [31:0] in_data = 32'd0, out_data;
   logic [1:0]  in_addr = 2'd0;
   logic [7:0]  err_cnt;

   logic        in_valid_b = 1'b0, in_ready_b, out_valid_b, out_ready_b = 1'b0, out_err_b;
   logic [2:0]  in_op_b = 3'd0;
   logic [63:0] in_data_b = 64'd0, out_data_b;
   logic [2:0]  in_addr_b = 3'd0;
   logic [1:0]  err_cnt_b;

   int tests = 0;
   int fails = 0;
   int exp_err = 0;

   always #5 clk = ~clk;

   ext_pipe dut (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_data(in_data), .in_addr(in_addr),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
      .err_cnt(err_cnt)
   );

   ext_pipe #(.IN_W(12), .OUT_W(64), .ERR_CNT_W(2)) dut_b (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid_b), .in_ready(in_ready_b), .in_op(in_op_b), .in_data(in_data_b),
      .in_addr(in_addr_b), .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
      .out_err(out_err_b), .err_cnt(err_cnt_b)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] e_ext [4];
      logic [2:0]  l_op  [4];
      logic [1:0]  l_adr [4];
      logic [31:0] l_dat [4];
      logic        l_err [4];
      e_ext = '{32'h0000_8001, 32'hFFFF_8001, 32'h8001_0000, 32'hFFFE_0004};
      l_op  = '{3'd5, 3'd4, 3'd7, 3'd6};
      l_adr = '{2'd1, 2'd3, 2'd2, 2'd1};
      l_dat = '{32'hFFFF_FFB3, 32'h0000_0011, 32'h0000_11A2, 32'h0000_0000};
      l_err = '{1'b0, 1'b0, 1'b0, 1'b1};

      // reset values
      #1 reset_n = 1'b0;
      #11;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_out_err", 64'(out_err), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_err_cnt", 64'(err_cnt), 64'd0);
      reset_n = 1'b1;

      // ops 0..3 back to back, one result per cycle
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 32'h0000_8001;
      for (int k = 0; k < 4; k++) begin
         in_op = 3'(k);
         tick();
         chk($sformatf("op%0d_valid", k), 64'(out_valid), 64'd1);
         chk($sformatf("op%0d_data", k), 64'(out_data), 64'(e_ext[k]));
         chk($sformatf("op%0d_err", k), 64'(out_err), 64'd0);
      end

      // load modes (reserved when the load feature is not built)
      in_data = 32'h11A2_B380;
      for (int k = 0; k < 4; k++) begin
         logic [31:0] ed;
         logic        ee;
`ifdef EXT_LOAD_EN
         ed = l_dat[k];
         ee = l_err[k];
`else
         ed = 32'd0;
         ee = 1'b1;
`endif
         in_op   = l_op[k];
         in_addr = l_adr[k];
         tick();
         if (ee) exp_err++;
         chk($sformatf("ld%0d_data", k), 64'(out_data), 64'(ed));
         chk($sformatf("ld%0d_err", k), 64'(out_err), 64'(ee));
         chk($sformatf("ld%0d_cnt", k), 64'(err_cnt), 64'(exp_err));
      end
      in_valid = 1'b0;
      in_op    = 3'd0;
      in_addr  = 2'd0;
      tick();
      chk("drain_valid", 64'(out_valid), 64'd0);

      // backpressure: three items offered, two buffered, FIFO order on release
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'd1;
      tick();
      chk("bp_a_valid", 64'(out_valid), 64'd1);
      chk("bp_a_data", 64'(out_data), 64'd1);
      in_data = 32'd2;
      tick();
      chk("bp_full_ready", 64'(in_ready), 64'd0);
      chk("bp_hold_data", 64'(out_data), 64'd1);
      in_data = 32'd3;
      tick();
      chk("bp_still_ready", 64'(in_ready), 64'd0);
      chk("bp_still_data", 64'(out_data), 64'd1);
      out_ready = 1'b1;
      tick();
      chk("bp_b_data", 64'(out_data), 64'd2);
      chk("bp_ready_back", 64'(in_ready), 64'd1);
      tick();
      chk("bp_c_data", 64'(out_data), 64'd3);
      in_valid = 1'b0;
      tick();
      chk("bp_empty", 64'(out_valid), 64'd0);

      // flush with both entries full
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h10;
      tick();
      in_data = 32'h20;
      tick();
      chk("fl_full", 64'(in_ready), 64'd0);
      flush   = 1'b1;
      in_data = 32'h30;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("fl_valid", 64'(out_valid), 64'd0);
      chk("fl_ready", 64'(in_ready), 64'd1);

      // an erroneous item accepted in the flush cycle is neither kept nor counted
      in_valid = 1'b1;
      in_data  = 32'h40;
      tick();
      flush   = 1'b1;
      in_op   = 3'd6;
      in_addr = 2'd1;
      in_data = 32'h50;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      in_op    = 3'd0;
      in_addr  = 2'd0;
      chk("fl2_valid", 64'(out_valid), 64'd0);
      chk("fl2_cnt", 64'(err_cnt), 64'(exp_err));
      out_ready = 1'b1;
      tick();
      chk("fl2_never", 64'(out_valid), 64'd0);

      // wide instance: IN_W=12 sign extension to 64 bits
      out_ready_b = 1'b1;
      in_valid_b  = 1'b1;
      in_op_b     = 3'd1;
      in_data_b   = 64'h800;
      tick();
      chk("w_sext", out_data_b, 64'hFFFF_FFFF_FFFF_F800);
      chk("w_err", 64'(out_err_b), 64'd0);

      // 2-bit error counter saturates after three errors
      in_op_b   = 3'd6;
      in_addr_b = 3'd1;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk($sformatf("sat%0d_cnt", k), 64'(err_cnt_b), 64'((k + 1 > 3) ? 3 : k + 1));
         chk($sformatf("sat%0d_err", k), 64'(out_err_b), 64'd1);
      end

      // reset mid-stream takes effect without a clock edge
      #2 reset_n = 1'b0;
      #1;
      chk("ar_valid", 64'(out_valid_b), 64'd0);
      chk("ar_data", out_data_b, 64'd0);
      chk("ar_err", 64'(out_err_b), 64'd0);
      chk("ar_cnt", 64'(err_cnt_b), 64'd0);
      chk("ar_ready", 64'(in_ready_b), 64'd1);
      chk("ar_cnt_a", 64'(err_cnt), 64'd0);
      in_valid_b = 1'b0;
      #3 reset_n = 1'b1;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
